epass_validator: RTL

EPASS_VALIDATOR -- requirements
Module: epass_validator

---
 rtl/epass_validator_if.sv | 26 ++
 rtl/epass_validator.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/epass_validator_if.sv
// Controller/account bus of the e-pass toll validator.
// The master drives strobes and account loads; the slave returns verdict, pulses, fee and balance.
interface epass_validator_if;
    logic       init;
    logic       count;
    logic       cal;
    logic       load_bal;
    logic [7:0] bal_in;
    logic       topup_valid;
    logic [7:0] topup_amt;
    logic [1:0] valid_Epass;
    logic       enable;
    logic       done;
    logic [7:0] fee;
    logic [7:0] balance;

    modport master (
        output init, count, cal, load_bal, bal_in, topup_valid, topup_amt,
        input  valid_Epass, enable, done, fee, balance
    );

    modport slave (
        input  init, count, cal, load_bal, bal_in, topup_valid, topup_amt,
        output valid_Epass, enable, done, fee, balance
    );
endinterface

// File: rtl/epass_validator.sv
// E-pass toll validator: times the trip, charges BASE_FEE + (timer >> TIME_SHIFT), reports paid/rejected.
// Optional EPASS_TOPUP_EN: top-ups recover a rejected pass; otherwise the lane is released after FAIL_HOLD cycles.
module epass_validator #(
    parameter logic [7:0]  BASE_FEE   = 8'd10,
    parameter int unsigned TIME_SHIFT = 2,
    parameter logic [7:0]  FAIL_HOLD  = 8'd16
) (
    input logic              clk,
    input logic              reset,
    epass_validator_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        TIMING,
        CHECK,
        OK,
        FAIL
    } state_t;

    state_t     state;
    logic [7:0] timer;
    logic [8:0] fee_sum;
    logic [7:0] fee_next;

    assign fee_sum  = {1'b0, BASE_FEE} + {1'b0, (timer >> TIME_SHIFT)};
    assign fee_next = fee_sum[8] ? 8'hFF : fee_sum[7:0];

`ifdef EPASS_TOPUP_EN
    logic [8:0] topup_sum;
    logic [7:0] topup_bal;

    assign topup_sum = {1'b0, bus.balance} + {1'b0, bus.topup_amt};
    assign topup_bal = topup_sum[8] ? 8'hFF : topup_sum[7:0];

    localparam logic [7:0] unused_fail_hold = FAIL_HOLD;
`else
    logic [7:0] hold_cnt;
    logic       hold_over;
    logic       unused_topup;

    assign hold_over    = ({1'b0, hold_cnt} + 9'd1) >= {1'b0, FAIL_HOLD};
    assign unused_topup = ^{bus.topup_valid, bus.topup_amt};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            timer           <= '0;
            bus.fee         <= '0;
            bus.balance     <= '0;
            bus.valid_Epass <= '0;
            bus.enable      <= 1'b0;
            bus.done        <= 1'b0;
`ifndef EPASS_TOPUP_EN
            hold_cnt        <= '0;
`endif
        end else begin
            bus.enable <= 1'b0;
            bus.done   <= 1'b0;
            case (state)
                IDLE: begin
                    bus.valid_Epass <= 2'b00;
                    if (bus.load_bal) begin
                        bus.balance <= bus.bal_in;
                    end
`ifdef EPASS_TOPUP_EN
                    else if (bus.topup_valid) begin
                        bus.balance <= topup_bal;
                    end
`endif
                    if (bus.init) begin
                        timer <= '0;
                    end else if (bus.cal) begin
                        state <= CHECK;
                    end else if (bus.count) begin
                        timer <= 8'd1;
                        state <= TIMING;
                    end
                end

                TIMING: begin
`ifdef EPASS_TOPUP_EN
                    if (bus.topup_valid) begin
                        bus.balance <= topup_bal;
                    end
`endif
                    if (bus.init) begin
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        if (bus.count && timer != 8'hFF) begin
                            timer <= timer + 8'd1;
                        end
                        if (bus.cal) begin
                            state <= CHECK;
                        end
                    end
                end

                CHECK: begin
                    bus.fee <= fee_next;
                    if (bus.balance >= fee_next) begin
                        bus.balance     <= bus.balance - fee_next;
                        bus.valid_Epass <= 2'b10;
                        bus.done        <= 1'b1;
                        state           <= OK;
                    end else begin
                        bus.valid_Epass <= 2'b01;
                        state           <= FAIL;
`ifndef EPASS_TOPUP_EN
                        hold_cnt        <= '0;
`endif
                    end
                end

                OK: begin
                    bus.valid_Epass <= 2'b00;
                    state           <= IDLE;
                end

                FAIL: begin
                    if (bus.init) begin
                        bus.valid_Epass <= 2'b00;
                        state           <= IDLE;
                    end
`ifdef EPASS_TOPUP_EN
                    else if (bus.topup_valid) begin
                        // Re-check reuses the frozen timer, so the same fee is charged.
                        bus.balance     <= topup_bal;
                        bus.valid_Epass <= 2'b00;
                        state           <= CHECK;
                    end
`else
                    else if (bus.enable) begin
                        // The release pulse occupies the last FAIL cycle.
                        bus.valid_Epass <= 2'b00;
                        state           <= IDLE;
                    end else if (hold_over) begin
                        bus.enable <= 1'b1;
                        bus.done   <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
